// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule constants, controller state encoding and GF(2^8) helpers.
package aes_pkg;

   localparam int         AES_NR    = 10;
   localparam int         AES_NK    = 4;
   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] RCON_POLY = 8'h1b;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EMIT,
      ST_EXPAND
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] s;
      logic [7:0] r;
      s = b;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_subword.sv
// SubWord: four parallel S-box lanes over a 32-bit word.
module aes_key_sched_ctrl_subword
   import aes_pkg::*;
(
   input  logic [31:0] i_word,
   output logic [31:0] o_word
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign o_word[8*gi +: 8] = sbox(i_word[8*gi +: 8]);
      end
   endgenerate

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion controller: one expanded word per cycle, round keys streamed out on valid/ready.
module aes_key_sched_ctrl
   import aes_pkg::*;
#(
   parameter int NR    = AES_NR,
   parameter int KEY_W = 32 * AES_NK
)
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [KEY_W-1:0] i_key,
   input  logic             i_abort,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [KEY_W-1:0] o_rkey,
   output logic [3:0]       o_round,
   output logic             o_busy,
   output logic             o_done
);

   state_t           state_reg;
   logic [KEY_W-1:0] win_reg;
   logic [1:0]       j_reg;
   logic [3:0]       round_reg;
   logic [7:0]       rcon_reg;

   logic [31:0]      w0;
   logic [31:0]      w3;
   logic [31:0]      sub_word;
   logic [31:0]      n_word;
   logic [KEY_W-1:0] win_next;

   assign w0       = win_reg[KEY_W-1 -: 32];
   assign w3       = win_reg[31:0];
   assign win_next = {win_reg[KEY_W-33:0], n_word};
   assign o_round  = round_reg;

   aes_key_sched_ctrl_subword u_subword (
      .i_word (({w3[23:0], w3[31:24]})),
      .o_word (sub_word)
   );

   // After the first word of a round, W[3] is exactly the word produced the cycle before.
   always_comb begin
      n_word = w0 ^ w3;
      if (j_reg == 2'd0) begin
         n_word = w0 ^ sub_word ^ {rcon_reg, 24'h0};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= ST_IDLE;
         win_reg   <= '0;
         j_reg     <= 2'd0;
         round_reg <= 4'd0;
         rcon_reg  <= RCON_INIT;
         o_valid   <= 1'b0;
         o_rkey    <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (state_reg != ST_IDLE && i_abort) begin
            state_reg <= ST_IDLE;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (i_start && !i_abort) begin
                     win_reg   <= i_key;
                     round_reg <= 4'd0;
                     rcon_reg  <= RCON_INIT;
                     o_rkey    <= i_key;
                     o_valid   <= 1'b1;
                     o_busy    <= 1'b1;
                     state_reg <= ST_EMIT;
                  end
               end
               ST_EMIT: begin
                  if (i_ready) begin
                     o_valid <= 1'b0;
                     if (round_reg == 4'(NR)) begin
                        state_reg <= ST_IDLE;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                     end else begin
                        state_reg <= ST_EXPAND;
                        j_reg     <= 2'd0;
                     end
                  end
               end
               ST_EXPAND: begin
                  win_reg <= win_next;
                  j_reg   <= j_reg + 2'd1;
                  if (j_reg == 2'd3) begin
                     round_reg <= round_reg + 4'd1;
                     rcon_reg  <= xtime(rcon_reg);
                     o_rkey    <= win_next;
                     o_valid   <= 1'b1;
                     state_reg <= ST_EMIT;
                  end
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for the AES-128 key-schedule controller using FIPS-197 and all-zero key vectors.
module tb_aes_key_sched_ctrl;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         i_start = 1'b0;
   logic [127:0] i_key = '0;
   logic         i_abort = 1'b0;
   logic         i_ready = 1'b0;
   logic         o_valid;
   logic [127:0] o_rkey;
   logic [3:0]   o_round;
   logic         o_busy;
   logic         o_done;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;

   logic [127:0] fips_rk [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   aes_key_sched_ctrl dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_start),
      .i_key   (i_key),
      .i_abort (i_abort),
      .i_ready (i_ready),
      .o_valid (o_valid),
      .o_rkey  (o_rkey),
      .o_round (o_round),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic start_key(input logic [127:0] key);
      i_key   = key;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      i_key   = '0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      tick();
      tick();
      i_rst = 1'b0;
      tick();
      vectors++;
      if ({o_valid, o_busy, o_done, o_round} !== 7'b0 || o_rkey !== 128'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b b=%b d=%b r=%0d k=%h, exp all zero",
                  o_valid, o_busy, o_done, o_round, o_rkey);
      end
   endtask

   task automatic test_fips_ready_high();
      int k = 0;
      int c = 1;
      int done_at = -1;
      i_ready = 1'b1;
      start_key(FIPS_KEY);
      while (c <= 120 && done_at < 0) begin
         if (o_valid) begin
            vectors++;
            if (k > 10) begin
               miscompares++;
               $display("FAIL fips_extra_key: got round %0d at cycle %0d, exp none", o_round, c);
            end else if (o_rkey !== fips_rk[k] || o_round !== 4'(k) || c != 1 + 5*k) begin
               miscompares++;
               $display("FAIL fips_rk%0d: got %h r=%0d cyc=%0d, exp %h r=%0d cyc=%0d",
                        k, o_rkey, o_round, c, fips_rk[k], k, 1 + 5*k);
            end
            k++;
         end
         if (o_done) done_at = c;
         c++;
         if (done_at < 0) tick();
      end
      vectors++;
      if (k != 11 || done_at != 52 || o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL fips_done: got keys=%0d done_at=%0d busy=%b, exp keys=11 done_at=52 busy=0",
                  k, done_at, o_busy);
      end
   endtask

   task automatic test_zero_key();
      i_ready = 1'b1;
      start_key(128'h0);
      vectors++;
      if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_rkey !== 128'h0 || o_round !== 4'd0) begin
         miscompares++;
         $display("FAIL zero_rk0: got v=%b b=%b %h r=%0d, exp v=1 b=1 0 r=0",
                  o_valid, o_busy, o_rkey, o_round);
      end
      repeat (5) tick();
      vectors++;
      if (o_valid !== 1'b1 || o_rkey !== ZERO_RK1 || o_round !== 4'd1) begin
         miscompares++;
         $display("FAIL zero_rk1: got v=%b %h r=%0d, exp v=1 %h r=1", o_valid, o_rkey, o_round, ZERO_RK1);
      end
      // abort coincides with a handshake here and must take priority
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      vectors++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_abort: got v=%b b=%b d=%b, exp 0 0 0", o_valid, o_busy, o_done);
      end
   endtask

   task automatic test_random_ready();
      int k = 0;
      bit stalled = 0;
      bit done = 0;
      logic [127:0] prev_key = '0;
      logic [3:0] prev_round = '0;
      i_ready = 1'b0;
      start_key(FIPS_KEY);
      for (int c = 0; c < 2000 && !done; c++) begin
         if (stalled) begin
            vectors++;
            if (o_valid !== 1'b1 || o_rkey !== prev_key || o_round !== prev_round) begin
               miscompares++;
               $display("FAIL rand_stall: got v=%b %h r=%0d, exp v=1 %h r=%0d",
                        o_valid, o_rkey, o_round, prev_key, prev_round);
            end
         end
         if (o_done) done = 1;
         stalled = 0;
         i_ready = 1'($urandom_range(0, 1));
         if (o_valid) begin
            if (i_ready) begin
               vectors++;
               if (k > 10 || o_rkey !== fips_rk[k > 10 ? 10 : k] || o_round !== 4'(k)) begin
                  miscompares++;
                  $display("FAIL rand_rk%0d: got %h r=%0d, exp %h r=%0d",
                           k, o_rkey, o_round, fips_rk[k > 10 ? 10 : k], k);
               end
               k++;
            end else begin
               stalled    = 1;
               prev_key   = o_rkey;
               prev_round = o_round;
            end
         end
         tick();
      end
      vectors++;
      if (!done || k != 11) begin
         miscompares++;
         $display("FAIL rand_done: got done=%b keys=%0d, exp done=1 keys=11", done, k);
      end
      i_ready = 1'b1;
   endtask

   task automatic test_start_while_busy();
      int k = 0;
      int c = 1;
      int done_at = -1;
      i_ready = 1'b1;
      start_key(FIPS_KEY);
      while (c <= 120 && done_at < 0) begin
         if (o_valid) begin
            vectors++;
            if (k > 10 || o_rkey !== fips_rk[k > 10 ? 10 : k] || o_round !== 4'(k)) begin
               miscompares++;
               $display("FAIL busy_rk%0d: got %h r=%0d, exp %h r=%0d",
                        k, o_rkey, o_round, fips_rk[k > 10 ? 10 : k], k);
            end
            k++;
         end
         if (o_done) done_at = c;
         i_start = (c == 1 || c == 3 || c == 6 || c == 23);
         i_key   = i_start ? 128'h0 : 128'h0;
         c++;
         if (done_at < 0) tick();
      end
      i_start = 1'b0;
      vectors++;
      if (k != 11 || done_at != 52) begin
         miscompares++;
         $display("FAIL busy_done: got keys=%0d done_at=%0d, exp keys=11 done_at=52", k, done_at);
      end
   endtask

   task automatic test_abort();
      bit seen = 0;
      i_ready = 1'b1;
      start_key(FIPS_KEY);
      repeat (17) tick();
      vectors++;
      if (o_valid !== 1'b0 || o_busy !== 1'b1 || o_round !== 4'd3) begin
         miscompares++;
         $display("FAIL abort_pre: got v=%b b=%b r=%0d, exp v=0 b=1 r=3", o_valid, o_busy, o_round);
      end
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      vectors++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_post: got v=%b b=%b, exp 0 0", o_valid, o_busy);
      end
      repeat (60) begin
         if (o_done || o_valid || o_busy) seen = 1;
         tick();
      end
      vectors++;
      if (seen) begin
         miscompares++;
         $display("FAIL abort_quiet: got activity=1, exp activity=0");
      end
      i_abort = 1'b1;
      i_start = 1'b1;
      i_key   = FIPS_KEY;
      tick();
      i_abort = 1'b0;
      i_start = 1'b0;
      vectors++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_start_idle: got v=%b b=%b, exp 0 0", o_valid, o_busy);
      end
      start_key(128'h0);
      vectors++;
      if (o_valid !== 1'b1 || o_rkey !== 128'h0 || o_round !== 4'd0) begin
         miscompares++;
         $display("FAIL abort_restart_rk0: got v=%b %h r=%0d, exp v=1 0 r=0", o_valid, o_rkey, o_round);
      end
      repeat (5) tick();
      vectors++;
      if (o_valid !== 1'b1 || o_rkey !== ZERO_RK1 || o_round !== 4'd1) begin
         miscompares++;
         $display("FAIL abort_restart_rk1: got v=%b %h r=%0d, exp v=1 %h r=1",
                  o_valid, o_rkey, o_round, ZERO_RK1);
      end
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
   endtask

   task automatic test_async_reset();
      i_ready = 1'b0;
      start_key(FIPS_KEY);
      tick();
      tick();
      vectors++;
      if (o_valid !== 1'b1 || o_rkey !== fips_rk[0]) begin
         miscompares++;
         $display("FAIL rst_stall: got v=%b %h, exp v=1 %h", o_valid, o_rkey, fips_rk[0]);
      end
      #3;
      i_rst = 1'b1;
      #1;
      vectors++;
      if ({o_valid, o_busy, o_done, o_round} !== 7'b0 || o_rkey !== 128'h0) begin
         miscompares++;
         $display("FAIL rst_async: got v=%b b=%b d=%b r=%0d k=%h, exp all zero",
                  o_valid, o_busy, o_done, o_round, o_rkey);
      end
      tick();
      i_rst   = 1'b0;
      i_ready = 1'b1;
      tick();
      vectors++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_no_partial: got v=%b b=%b, exp 0 0", o_valid, o_busy);
      end
      start_key(FIPS_KEY);
      vectors++;
      if (o_valid !== 1'b1 || o_rkey !== fips_rk[0] || o_round !== 4'd0) begin
         miscompares++;
         $display("FAIL rst_restart_rk0: got v=%b %h r=%0d, exp v=1 %h r=0",
                  o_valid, o_rkey, o_round, fips_rk[0]);
      end
      repeat (5) tick();
      vectors++;
      if (o_valid !== 1'b1 || o_rkey !== fips_rk[1] || o_round !== 4'd1) begin
         miscompares++;
         $display("FAIL rst_restart_rk1: got v=%b %h r=%0d, exp v=1 %h r=1",
                  o_valid, o_rkey, o_round, fips_rk[1]);
      end
   endtask

   initial begin
      test_reset();
      test_fips_ready_high();
      test_zero_key();
      test_random_ready();
      test_start_while_busy();
      test_abort();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, exp completion");
      $fatal(1, "timeout");
   end

endmodule
